// File: rtl/cpu_mem_loader.sv
// Memory stage for the accumulator CPU: unified program/data RAM plus a host load port
// that holds the CPU in reset while a program image is streamed in.
module cpu_mem_loader #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LOAD_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ce,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0]     i_data,
    output logic [DWIDTH-1:0]     o_data,
    input  logic                  i_ld_start,
    input  logic                  i_ld_valid,
    input  logic [DWIDTH-1:0]     i_ld_data,
    output logic                  o_ld_ready,
    input  logic                  i_ld_done,
    output logic                  o_cpu_rst_n,
    output logic [ADDR_WIDTH:0]   o_ld_count,
    output logic                  o_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FullCount = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BaseAddr  = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [1:0] {StHalt, StLoad, StRun} state_e;

    state_e              state_q;
    logic [DWIDTH-1:0]   mem [DEPTH];

    logic                ld_accept;
    logic                cpu_rd;
    logic                cpu_wr;
    logic                ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0]   ram_wdata;
    logic [ADDR_WIDTH:0] count_next;

    // One shared RAM port: the loader owns it in LOAD, the CPU in RUN.
    always_comb begin
        ld_accept  = (state_q == StLoad) && i_ld_valid && o_ld_ready;
        cpu_rd     = (state_q == StRun) && i_ce && !i_we;
        cpu_wr     = (state_q == StRun) && i_ce && i_we;
        ram_we     = ld_accept || cpu_wr;
        ram_addr   = (state_q == StLoad) ? (BaseAddr + o_ld_count[ADDR_WIDTH-1:0]) : i_addr;
        ram_wdata  = (state_q == StLoad) ? i_ld_data : i_data;
        count_next = o_ld_count + (ADDR_WIDTH + 1)'(ld_accept);
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data <= '0;
        end else if (cpu_rd) begin
            o_data <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StHalt;
            o_cpu_rst_n <= 1'b0;
            o_ld_ready  <= 1'b0;
            o_ld_count  <= '0;
            o_err       <= 1'b0;
        end else begin
            if (i_ce && state_q != StRun) begin
                o_err <= 1'b1;
            end
            case (state_q)
                StHalt: begin
                    if (i_ld_start) begin
                        state_q    <= StLoad;
                        o_ld_count <= '0;
                        o_ld_ready <= 1'b1;
                    end
                end
                StLoad: begin
                    o_ld_count <= count_next;
                    if (i_ld_valid && !o_ld_ready) begin
                        o_err <= 1'b1;
                    end
                    // Done takes priority over start; a word accepted this cycle still lands.
                    if (i_ld_done) begin
                        state_q     <= StRun;
                        o_ld_ready  <= 1'b0;
                        o_cpu_rst_n <= 1'b1;
                    end else begin
                        o_ld_ready <= (count_next != FullCount);
                    end
                end
                StRun: begin
                    if (i_ld_start) begin
                        state_q     <= StLoad;
                        o_ld_count  <= '0;
                        o_ld_ready  <= 1'b1;
                        o_cpu_rst_n <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: two instances (load base 0 and 0xFFE) share stimulus and are
// checked every cycle against an array-based reference model.
module tb_cpu_mem_loader;

    localparam int Depth = 4096;
    localparam int MHalt = 0;
    localparam int MLoad = 1;
    localparam int MRun  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce, we, start, valid, done;
    logic [11:0] addr;
    logic [15:0] wdata, ldata;

    logic [1:0][15:0] dut_data;
    logic [1:0][12:0] dut_count;
    logic [1:0]       dut_ready, dut_rst_n, dut_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem   [2][Depth];
    bit          m_wr    [2][Depth];
    int          m_state [2];
    int          m_cnt   [2];
    bit          m_err   [2];
    logic [15:0] m_data  [2];
    bit          m_known [2];
    int          m_base  [2] = '{0, 'hFFE};

    always #5 clk = ~clk;

    cpu_mem_loader #(.DWIDTH(16), .ADDR_WIDTH(12), .LOAD_BASE(0)) u_dut0 (
        .clk(clk), .reset(reset), .i_ce(ce), .i_we(we), .i_addr(addr), .i_data(wdata),
        .o_data(dut_data[0]), .i_ld_start(start), .i_ld_valid(valid), .i_ld_data(ldata),
        .o_ld_ready(dut_ready[0]), .i_ld_done(done), .o_cpu_rst_n(dut_rst_n[0]),
        .o_ld_count(dut_count[0]), .o_err(dut_err[0])
    );

    cpu_mem_loader #(.DWIDTH(16), .ADDR_WIDTH(12), .LOAD_BASE('hFFE)) u_dut1 (
        .clk(clk), .reset(reset), .i_ce(ce), .i_we(we), .i_addr(addr), .i_data(wdata),
        .o_data(dut_data[1]), .i_ld_start(start), .i_ld_valid(valid), .i_ld_data(ldata),
        .o_ld_ready(dut_ready[1]), .i_ld_done(done), .o_cpu_rst_n(dut_rst_n[1]),
        .o_ld_count(dut_count[1]), .o_err(dut_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = MHalt;
            m_cnt[k]   = 0;
            m_err[k]   = 1'b0;
            m_data[k]  = '0;
            m_known[k] = 1'b1;
        end
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int st = m_state[k];
            if (ce && st != MRun) m_err[k] = 1'b1;
            case (st)
                MHalt: if (start) begin m_state[k] = MLoad; m_cnt[k] = 0; end
                MLoad: begin
                    if (valid) begin
                        if (m_cnt[k] < Depth) begin
                            int a = (m_base[k] + m_cnt[k]) % Depth;
                            m_mem[k][a] = ldata;
                            m_wr[k][a]  = 1'b1;
                            m_cnt[k]++;
                        end else begin
                            m_err[k] = 1'b1;
                        end
                    end
                    if (done) m_state[k] = MRun;
                end
                default: begin
                    if (ce && we) begin
                        m_mem[k][addr] = wdata;
                        m_wr[k][addr]  = 1'b1;
                    end else if (ce) begin
                        m_data[k]  = m_mem[k][addr];
                        m_known[k] = m_wr[k][addr];
                    end
                    if (start) begin m_state[k] = MLoad; m_cnt[k] = 0; end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("cpu_rst_n%0d", k), 32'(dut_rst_n[k]), 32'(m_state[k] == MRun));
            check_eq($sformatf("ld_ready%0d", k), 32'(dut_ready[k]),
                     32'(m_state[k] == MLoad && m_cnt[k] < Depth));
            check_eq($sformatf("ld_count%0d", k), 32'(dut_count[k]), 32'(m_cnt[k]));
            check_eq($sformatf("err%0d", k), 32'(dut_err[k]), 32'(m_err[k]));
            if (m_known[k]) check_eq($sformatf("data%0d", k), 32'(dut_data[k]), 32'(m_data[k]));
        end
    endtask

    task automatic set_idle();
        ce = 0; we = 0; addr = '0; wdata = '0; start = 0; valid = 0; ldata = '0; done = 0;
    endtask

    // Inputs are applied just after a rising edge and sampled 1 time unit after the next one.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle_cycle();                      set_idle(); step(); endtask
    task automatic ld_start();                        start = 1; step(); endtask
    task automatic ld_done();                         done = 1; step(); endtask
    task automatic load_word(input logic [15:0] d);   valid = 1; ldata = d; step(); endtask
    task automatic cpu_read(input logic [11:0] a);    ce = 1; addr = a; step(); endtask
    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        ce = 1; we = 1; addr = a; wdata = d; step();
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) for (int i = 0; i < Depth; i++) m_wr[k][i] = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic load with a gap, then RUN-side accesses.
        ld_start();
        load_word(16'h7001);
        load_word(16'h7002);
        idle_cycle();
        load_word(16'h7004);
        load_word(16'h7008);
        ld_done();
        cpu_read(12'd2);
        cpu_read(12'hFFE);
        cpu_read(12'd0);
        idle_cycle();
        cpu_write(12'h0A5, 16'hBEEF);
        cpu_read(12'h0A5);
        idle_cycle();

        // CPU access during LOAD is ignored and flags an error.
        ld_start();
        cpu_write(12'h0A5, 16'h1234);
        cpu_read(12'd1);
        ld_done();
        cpu_read(12'h0A5);

        // CPU access during HALT.
        do_reset();
        cpu_read(12'd3);
        idle_cycle();

        // Fill the whole RAM, then one valid too many.
        do_reset();
        ld_start();
        for (int i = 0; i < Depth; i++) load_word(16'($urandom));
        load_word(16'hDEAD);
        idle_cycle();
        ld_done();
        cpu_read(12'd0);
        cpu_read(12'hFFE);
        cpu_read(12'hFFF);

        // Reset in the middle of a load keeps the words already written.
        do_reset();
        ld_start();
        load_word(16'hA001);
        load_word(16'hA002);
        do_reset();
        ld_start();
        ld_done();
        cpu_read(12'd0);
        cpu_read(12'd1);
        cpu_read(12'hFFE);
        cpu_read(12'hFFF);
        ld_start();
        load_word(16'h5555);
        ld_done();

        // Simultaneous start and done in each state.
        start = 1; done = 1; step();
        start = 1; done = 1; valid = 1; ldata = 16'h6666; step();
        do_reset();
        start = 1; done = 1; step();
        ld_done();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 39) == 0);
            done  = ($urandom_range(0, 29) == 0);
            valid = $urandom_range(0, 1);
            ldata = 16'($urandom);
            ce    = ($urandom_range(0, 2) == 0);
            we    = $urandom_range(0, 1);
            addr  = $urandom_range(0, 1) ? 12'($urandom_range(0, 7))
                                         : 12'($urandom_range('hFF8, 'hFFF));
            wdata = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
Downstream memory stage for the accumulator CPU. It holds the unified program/data RAM of 2**ADDR_WIDTH words × DWIDTH bits. It serves the CPU's ce/we/addr/data memory port. It also owns the CPU's reset_n, holding the CPU in reset while a host streams a program image into RAM over a valid/ready load port, then releases it to run.

Parameters:
DWIDTH, 16, memory word width; matches the CPU data bus.
ADDR_WIDTH, 12, address width; RAM depth DEPTH = 2**ADDR_WIDTH.
LOAD_BASE, 0, first RAM address written by a load session (0..DEPTH-1).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
i_ce  input  1  CPU memory chip enable.
i_we  input  1  CPU write enable; qualified by i_ce.
i_addr  input  ADDR_WIDTH  CPU word address.
i_data  input  DWIDTH  CPU write data.
o_data  output  DWIDTH  read data to CPU.
i_ld_start  input  1  host request to enter LOAD.
i_ld_valid  input  1  host load word valid.
i_ld_data  input  DWIDTH  host load word.
o_ld_ready  output  1  loader can accept a word this cycle.
i_ld_done  input  1  host end-of-image; release CPU.
o_cpu_rst_n  output  1  active-low reset driven to the CPU.
o_ld_count  output  ADDR_WIDTH+1  words written in current/last load session.
o_err  output  1  sticky error flag.

Behaviour:
- Reset (async, active-high):
  - State forced to HALT.
  - Outputs: o_data=0, o_cpu_rst_n=0, o_ld_ready=0, o_ld_count=0, o_err=0.
  - RAM contents are not cleared.
- States: HALT, LOAD, RUN.
  - HALT: CPU held (o_cpu_rst_n=0), o_ld_ready=0. i_ld_start → LOAD, o_ld_count←0.
  - LOAD: CPU held.
    - o_ld_ready=1 while o_ld_count<DEPTH.
    - Accepted word (i_ld_valid & o_ld_ready): RAM[(LOAD_BASE+o_ld_count) mod DEPTH]←i_ld_data, o_ld_count++.
    - i_ld_done → RUN. A word accepted in the same cycle as i_ld_done is written before the transition.
    - i_ld_start in LOAD is ignored.
  - RUN: o_cpu_rst_n=1, registered, so it is high from the first cycle in RUN; o_ld_ready=0. i_ld_start → LOAD, o_ld_count←0, and o_cpu_rst_n drops to 0 on that edge (CPU re-held).
- Load address wrap: LOAD_BASE+count wraps modulo DEPTH.
- Full condition: o_ld_count==DEPTH.
  - o_ld_ready deasserts and further valids are dropped.
  - i_ld_valid while full sets o_err.
- CPU port, honoured only in RUN:
  - Read: i_ce & ~i_we. o_data←RAM[i_addr] on the next edge (1-cycle latency). o_data holds its value when no read occurs.
  - Write: i_ce & i_we. RAM[i_addr]←i_data; o_data unchanged.
  - Read-during-write to the same address cannot occur (single port, one op per cycle).
  - i_ce while not in RUN: access ignored and o_err set.
- o_err is sticky until reset.
- Simultaneous i_ld_start and i_ld_done:
  - In HALT: start wins.
  - In LOAD: done wins.
  - In RUN: start wins.
- Arithmetic: o_ld_count is ADDR_WIDTH+1 bits so DEPTH is representable. The address adder is ADDR_WIDTH bits with natural truncation.
- Single-port synchronous RAM inference; no combinational path from inputs to o_data.

Test Plan:
- Reset, then i_ld_start, then 4 words 0x7001,0x7002,0x7004,0x7008 (one idle cycle between 2nd and 3rd), then i_ld_done → RAM[0..3] hold them; o_ld_count=4; o_cpu_rst_n rises on the first RUN cycle.
- In RUN, CPU read of addr 2 (i_ce=1,i_we=0) → o_data=0x7004 one cycle later. CPU write 0xBEEF to addr 0x0A5, then read back → o_data=0xBEEF.
- LOAD_BASE=0xFFE with 3 words → written at 0xFFE, 0xFFF, 0x000; o_ld_count=3.
- Load DEPTH (4096) words → o_ld_ready drops after the 4096th; one more i_ld_valid sets o_err=1; RAM[LOAD_BASE] keeps the first word.
- i_ce=1 during HALT or LOAD → no RAM change, o_data stays at its previous value, o_err=1.
- Assert reset mid-LOAD after 2 words → immediately state=HALT, o_ld_ready=0, o_ld_count=0, o_cpu_rst_n=0; RAM keeps the 2 words. Then i_ld_start in RUN reloads and re-holds the CPU (o_cpu_rst_n=0 next cycle).
